cache_mem_arbiter: RTL and testbench

Arbitrates a single main-memory line port between two caches (port 0 = instruction cache, port 1 = data cache). Each cache presents one 128-bit line transaction at a time (write-back or refill). The arbiter grants the port round-robin, holds the grant across a write-back + refill pair when asked, and reports a timeout if memory stalls. It sits between the cache blocks and main memory, replacing the caches' direct memory hookup.

---
 rtl/cache_mem_arbiter_pkg.sv | 17 +
 rtl/rr_picker2.sv | 37 +++
 rtl/cache_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory line port arbiter.
// State encoding, port ids and default geometry.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic PORT_ICACHE = 1'b0;
    localparam logic PORT_DCACHE = 1'b1;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WIDTH = 128;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin picker with an optional lock to one owner.
// Purely combinational.
module rr_picker2 (
    input  logic [1:0] req,
    input  logic       lastGrant,
    input  logic       lock,
    input  logic       lockOwner,
    output logic       grantValid,
    output logic       grantId
);

    always_comb begin
        grantValid = 1'b0;
        grantId    = ~lastGrant;
        if (lock) begin
            grantValid = req[lockOwner];
            grantId    = lockOwner;
        end else begin
            case (req)
                2'b01: begin
                    grantValid = 1'b1;
                    grantId    = 1'b0;
                end
                2'b10: begin
                    grantValid = 1'b1;
                    grantId    = 1'b1;
                end
                2'b11: begin
                    grantValid = 1'b1;
                    grantId    = ~lastGrant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory line port between the I-cache and D-cache.
// Round-robin grant, optional hold across a write-back/refill pair, timeout.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  isMemRead0,
    input  logic                  hold0,
    input  logic [ADDR_WIDTH-1:0] memAddress0,
    input  logic [LINE_WIDTH-1:0] memWriteData0,
    output logic                  ack0,
    output logic                  error0,
    output logic [LINE_WIDTH-1:0] readData0,
    input  logic                  req1,
    input  logic                  isMemRead1,
    input  logic                  hold1,
    input  logic [ADDR_WIDTH-1:0] memAddress1,
    input  logic [LINE_WIDTH-1:0] memWriteData1,
    output logic                  ack1,
    output logic                  error1,
    output logic [LINE_WIDTH-1:0] readData1,
    output logic                  memReq,
    output logic                  memIsRead,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [LINE_WIDTH-1:0] memWriteData,
    input  logic [LINE_WIDTH-1:0] memReadData,
    input  logic                  memReady
);

    localparam int TW = $clog2(MAX_WAIT + 1);

    state_t                state, state_n;
    logic                  owner, last_grant, lock, op, timeout;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata, rdata0, rdata1, line_in;
    logic [TW-1:0]         timer;
    logic [1:0]            ack, err, req_v, hold_v;
    logic                  lock_eff, gnt_v, gnt_id, done, expire, busy;

    assign req_v  = {req1, req0};
    assign hold_v = {hold1, hold0};

    // The lock drops as soon as the owner neither holds nor requests.
    assign lock_eff = lock && (hold_v[owner] || req_v[owner]);

    rr_picker2 u_picker (
        .req       (req_v),
        .lastGrant (last_grant),
        .lock      (lock_eff),
        .lockOwner (owner),
        .grantValid(gnt_v),
        .grantId   (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        expire  = 1'b0;
        unique case (state)
            IDLE: if (gnt_v) state_n = BUSY;
            BUSY: begin
                if (memReady) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (timer == TW'(MAX_WAIT - 1)) begin
                    expire  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign line_in = (done && op) ? memReadData : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lock       <= 1'b0;
            op         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            timer      <= '0;
            timeout    <= 1'b0;
            ack        <= '0;
            err        <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            unique case (state)
                IDLE: begin
                    lock <= lock_eff;
                    if (gnt_v) begin
                        owner   <= gnt_id;
                        timer   <= '0;
                        timeout <= 1'b0;
                        if (gnt_id == PORT_DCACHE) begin
                            op    <= isMemRead1;
                            addr  <= memAddress1;
                            wdata <= memWriteData1;
                        end else begin
                            op    <= isMemRead0;
                            addr  <= memAddress0;
                            wdata <= memWriteData0;
                        end
                    end
                end
                BUSY: begin
                    if (done || expire) begin
                        ack[owner] <= 1'b1;
                        err[owner] <= expire;
                        timeout    <= expire;
                        timer      <= '0;
                        if (owner == PORT_DCACHE) rdata1 <= line_in;
                        else                      rdata0 <= line_in;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    last_grant <= owner;
                    lock       <= hold_v[owner] && !timeout;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == BUSY);
    assign memReq       = busy;
    assign memIsRead    = busy && op;
    assign memAddress   = busy ? addr : '0;
    assign memWriteData = busy ? wdata : '0;

    assign ack0      = ack[PORT_ICACHE];
    assign ack1      = ack[PORT_DCACHE];
    assign error0    = err[PORT_ICACHE];
    assign error1    = err[PORT_DCACHE];
    assign readData0 = rdata0;
    assign readData1 = rdata1;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter.
// Hand-computed expectations checked with immediate assertions.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, isMemRead0, hold0, ack0, error0;
    logic         req1, isMemRead1, hold1, ack1, error1;
    logic [31:0]  memAddress0, memAddress1, memAddress;
    logic [127:0] memWriteData0, memWriteData1, memWriteData;
    logic [127:0] readData0, readData1, memReadData;
    logic         memReq, memIsRead, memReady;

    int errors = 0;
    int checks = 0;
    int cnt;
    logic [8:0] req_pat, ack_pat;

    localparam logic [127:0] D_A = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_0001;
    localparam logic [127:0] D_B = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D_C = 128'h0000_0000_0000_0000_0000_0000_0000_0055;
    localparam logic [127:0] D_D = 128'hDEAD_0000_0000_0000_0000_0000_0000_0077;
    localparam logic [127:0] W_1 = 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF;

    cache_mem_arbiter #(
        .ADDR_WIDTH(32),
        .LINE_WIDTH(128),
        .MAX_WAIT  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .isMemRead0   (isMemRead0),
        .hold0        (hold0),
        .memAddress0  (memAddress0),
        .memWriteData0(memWriteData0),
        .ack0         (ack0),
        .error0       (error0),
        .readData0    (readData0),
        .req1         (req1),
        .isMemRead1   (isMemRead1),
        .hold1        (hold1),
        .memAddress1  (memAddress1),
        .memWriteData1(memWriteData1),
        .ack1         (ack1),
        .error1       (error1),
        .readData1    (readData1),
        .memReq       (memReq),
        .memIsRead    (memIsRead),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memReadData  (memReadData),
        .memReady     (memReady)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; isMemRead0 = 0; hold0 = 0; memAddress0 = '0; memWriteData0 = '0;
        req1 = 0; isMemRead1 = 0; hold1 = 0; memAddress1 = '0; memWriteData1 = '0;
        memReadData = '0; memReady = 0;
        tick();
        tick();

        // reset state
        check("rst_memReq", memReq, 0);
        check("rst_memIsRead", memIsRead, 0);
        check("rst_memAddress", memAddress, 0);
        check("rst_memWriteData", memWriteData, 0);
        check("rst_ack", {ack1, ack0}, 0);
        check("rst_error", {error1, error0}, 0);
        check("rst_readData0", readData0, 0);
        check("rst_readData1", readData1, 0);

        // single read, memReady in second BUSY cycle
        reset = 0;
        req0 = 1; isMemRead0 = 1; memAddress0 = 32'h40;
        tick();
        check("rd_busy1_req", memReq, 1);
        check("rd_busy1_addr", memAddress, 32'h40);
        check("rd_busy1_dir", memIsRead, 1);
        check("rd_busy1_ack", ack0, 0);
        tick();
        check("rd_busy2_req", memReq, 1);
        memReady = 1; memReadData = D_A;
        tick();
        memReady = 0;
        check("rd_ack0", ack0, 1);
        check("rd_err0", error0, 0);
        check("rd_data0", readData0, D_A);
        check("rd_resp_req", memReq, 0);
        check("rd_ack1", ack1, 0);
        req0 = 0;
        tick();
        check("rd_idle_ack", ack0, 0);
        check("rd_idle_req", memReq, 0);

        // tie out of reset: order 0,1,0,1 with zero-wait memory
        reset = 1;
        tick();
        reset = 0;
        req0 = 1; memAddress0 = 32'h100;
        req1 = 1; isMemRead1 = 1; memAddress1 = 32'h200;
        memReady = 1; memReadData = D_B;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tie_addr", memAddress, (i % 2 == 1) ? 32'h200 : 32'h100);
            tick();
            check("tie_req_drop", memReq, 0);
            if (i % 2 == 1) begin
                check("tie_ack1", {ack1, ack0}, 2'b10);
                check("tie_data1", readData1, D_B);
            end else begin
                check("tie_ack0", {ack1, ack0}, 2'b01);
                check("tie_data0", readData0, D_B);
            end
            if (i == 3) begin
                req0 = 0;
                req1 = 0;
            end
            tick();
        end
        memReady = 0;

        // write-back + refill pair held by port 1, port 0 waiting
        req1 = 1; isMemRead1 = 0; memAddress1 = 32'h1A0;
        memWriteData1 = W_1; hold1 = 1;
        tick();
        check("hold_wb_addr", memAddress, 32'h1A0);
        check("hold_wb_dir", memIsRead, 0);
        check("hold_wb_data", memWriteData, W_1);
        req0 = 1; isMemRead0 = 1; memAddress0 = 32'h300;
        memReady = 1;
        tick();
        check("hold_wb_ack1", ack1, 1);
        check("hold_wb_err1", error1, 0);
        check("hold_wb_rd1", readData1, 0);
        isMemRead1 = 1; memAddress1 = 32'h120; memReady = 0;
        tick();
        check("hold_idle_req", memReq, 0);
        tick();
        check("hold_refill_addr", memAddress, 32'h120);
        check("hold_refill_dir", memIsRead, 1);
        memReady = 1; memReadData = D_C;
        tick();
        memReady = 0;
        check("hold_refill_ack1", ack1, 1);
        check("hold_refill_rd1", readData1, D_C);
        check("hold_refill_ack0", ack0, 0);
        tick();
        req1 = 0; hold1 = 0;
        tick();
        check("hold_release_addr", memAddress, 32'h300);
        check("hold_release_req", memReq, 1);
        memReady = 1; memReadData = D_D;
        tick();
        memReady = 0;
        check("hold_p0_ack0", ack0, 1);
        check("hold_p0_rd0", readData0, D_D);
        req0 = 0;
        tick();

        // timeout with hold0 set: lock must not survive
        req0 = 1; isMemRead0 = 1; memAddress0 = 32'h500; hold0 = 1;
        tick();
        cnt = 0;
        while (memReq && cnt < 40) begin
            cnt++;
            tick();
        end
        check("to_busy_cycles", cnt, 16);
        check("to_ack0", ack0, 1);
        check("to_err0", error0, 1);
        check("to_rd0", readData0, 0);
        memAddress0 = 32'h600; hold0 = 0;
        req1 = 1; isMemRead1 = 1; memAddress1 = 32'h700;
        tick();
        tick();
        check("to_unlock_addr", memAddress, 32'h700);
        memReady = 1; memReadData = D_B;
        tick();
        check("to_unlock_ack1", ack1, 1);
        req1 = 0; memReady = 0;
        tick();
        tick();
        check("late_addr", memAddress, 32'h600);
        for (int k = 1; k < 16; k++) tick();
        check("late_busy16", memReq, 1);
        memReady = 1; memReadData = D_A;
        tick();
        memReady = 0;
        check("late_ack0", ack0, 1);
        check("late_err0", error0, 0);
        check("late_rd0", readData0, D_A);
        req0 = 0;
        tick();

        // reset in the second BUSY cycle
        req1 = 1; isMemRead1 = 1; memAddress1 = 32'h800;
        tick();
        tick();
        check("rstmid_busy2", memReq, 1);
        reset = 1;
        tick();
        check("rstmid_req", memReq, 0);
        check("rstmid_ack", {ack1, ack0}, 0);
        reset = 0;
        req0 = 1; memAddress0 = 32'h900;
        tick();
        check("rstmid_tie_addr", memAddress, 32'h900);
        memReady = 1;
        tick();
        check("rstmid_ack0", ack0, 1);
        req0 = 0;
        tick();

        // zero-wait memory, port 1 continuously requesting
        memAddress1 = 32'hA00;
        req_pat = '0;
        ack_pat = '0;
        for (int t = 0; t < 9; t++) begin
            tick();
            req_pat[t] = memReq;
            ack_pat[t] = ack1;
        end
        check("zw_req_pattern", req_pat, 9'b001_001_001);
        check("zw_ack_pattern", ack_pat, 9'b010_010_010);
        req1 = 0; memReady = 0;
        tick();
        tick();
        check("end_idle_req", memReq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
